alt_vipitc121_is2vid_mode_sequencer: RTL

Sequences mode changes for the IS2Vid clocked-video output. It accepts a mode-change request and drives the bank select into the combinational mode-calculation datapath. It waits a fixed settle time for that multicycle path, then strobes the capture register that holds the calculated timing values. The new timing is committed to the sync/timing generator only at a frame boundary, or immediately when output is stopped.

---
 rtl/alt_vipitc121_IS2Vid_mode_seq_pkg.sv | 16 +
 rtl/alt_vipitc121_is2vid_mode_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/alt_vipitc121_IS2Vid_mode_seq_pkg.sv
// Shared constants for the IS2Vid mode-change sequencer.
// State encoding is kept as plain 3-bit constants for compatibility with older tools.
package alt_vipitc121_IS2Vid_mode_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_FB = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOAD    = 3'd4;

  localparam int SEQ_SETTLE_CYCLES_DEF = 3;
  localparam int SEQ_CNT_W             = 4;

endpackage

// File: rtl/alt_vipitc121_is2vid_mode_sequencer.sv
// Sequences a mode change: select bank, settle the multicycle calc path, capture,
// then commit the new timing at a frame boundary (or at once when output is stopped).
module alt_vipitc121_is2vid_mode_sequencer
  import alt_vipitc121_IS2Vid_mode_seq_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int MODE_W        = 4,
  parameter int SETTLE_CYCLES = SEQ_SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  input  logic              frame_boundary,
  output logic [MODE_W-1:0] mode_sel,
  output logic              calc_load,
  output logic              timing_load,
  output logic [MODE_W-1:0] active_mode,
  output logic              mode_valid,
  output logic              busy,
  output logic              bad_mode
);

  // One extra bit so NUM_MODES == 2**MODE_W still compares correctly.
  localparam logic [MODE_W:0]        NUM_MODES_V = (MODE_W + 1)'(NUM_MODES);
  localparam logic [SEQ_CNT_W-1:0]   CNT_INIT    = SEQ_CNT_W'(SETTLE_CYCLES - 1);

  logic [STATE_W-1:0]   r_state;
  logic [SEQ_CNT_W-1:0] r_cnt;
  logic [MODE_W-1:0]    r_mode_sel;
  logic [MODE_W-1:0]    r_active_mode;
  logic                 r_mode_valid;
  logic                 r_bad_mode;
  logic                 r_calc_load;
  logic                 r_timing_load;
  logic                 r_busy;

  logic [STATE_W-1:0]   w_state_nxt;
  logic                 w_hs;
  logic                 w_bad;
  logic                 w_redundant;
  logic                 w_start;

  assign req_ready   = (r_state == ST_IDLE);
  assign w_hs        = req_valid && req_ready;
  assign w_bad       = ({1'b0, req_mode} >= NUM_MODES_V);
  assign w_redundant = r_mode_valid && (req_mode == r_active_mode);
  assign w_start     = w_hs && !w_bad && !w_redundant;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (r_cnt == '0) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_WAIT_FB;
      // The first mode after reset has nothing on screen to protect, so it loads at once.
      ST_WAIT_FB: if (frame_boundary || !go || !r_mode_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_mode_sel    <= '0;
      r_active_mode <= '0;
      r_mode_valid  <= 1'b0;
      r_bad_mode    <= 1'b0;
      r_calc_load   <= 1'b0;
      r_timing_load <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_calc_load   <= (w_state_nxt == ST_CAPTURE);
      r_timing_load <= (w_state_nxt == ST_LOAD);
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_mode_sel <= req_mode;
        r_cnt      <= CNT_INIT;
      end else if (r_state == ST_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - SEQ_CNT_W'(1);
      end
      if (w_hs && w_bad) r_bad_mode <= 1'b1;
      if (r_state == ST_LOAD) begin
        r_active_mode <= r_mode_sel;
        r_mode_valid  <= 1'b1;
      end
    end
  end

  assign mode_sel    = r_mode_sel;
  assign calc_load   = r_calc_load;
  assign timing_load = r_timing_load;
  assign active_mode = r_active_mode;
  assign mode_valid  = r_mode_valid;
  assign busy        = r_busy;
  assign bad_mode    = r_bad_mode;

endmodule
